// File: rtl/deserializer_fsm.sv
// deserializer_fsm: bit-serial to parallel receiver, LSB first by default (MSB first with DESERIALIZER_MSB_FIRST_EN)
module deserializer_fsm #(
  parameter int LENGTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_ready
);
  localparam int CNT_BITS = $clog2(LENGTH);
  typedef enum logic [2:0] {IDLE = 3'b000, SHIFT_IN = 3'b010, OUTPUT = 3'b100} state_t;
  state_t state, state_n;
  logic [CNT_BITS-1:0] counter, counter_n;
  logic [LENGTH-1:0] shift_reg, shift_reg_n, shifted, dout_n;
  logic valid_n, accept, last;
  assign o_ready = state == SHIFT_IN;
  assign accept = o_ready && i_din_valid;
  assign last = counter == CNT_BITS'(LENGTH - 1);
`ifdef DESERIALIZER_MSB_FIRST_EN
  assign shifted = {shift_reg[LENGTH-2:0], i_din};
`else
  assign shifted = {i_din, shift_reg[LENGTH-1:1]};
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      counter      <= '0;
      shift_reg    <= '0;
      ov_dout      <= '0;
      o_dout_valid <= 1'b0;
    end else if (i_en) begin
      state        <= state_n;
      counter      <= counter_n;
      shift_reg    <= shift_reg_n;
      ov_dout      <= dout_n;
      o_dout_valid <= valid_n;
    end
  end
  always_comb begin
    state_n     = state;
    counter_n   = counter;
    shift_reg_n = shift_reg;
    dout_n      = ov_dout;
    valid_n     = o_dout_valid;
    case (state)
      IDLE: begin
        counter_n   = '0;
        shift_reg_n = '0;
        state_n     = SHIFT_IN;
      end
      SHIFT_IN: if (accept) begin
        shift_reg_n = shifted;
        counter_n   = last ? '0 : counter + 1'b1;
        dout_n      = last ? shifted : ov_dout;
        valid_n     = last;
        state_n     = last ? OUTPUT : SHIFT_IN;
      end
      OUTPUT: begin
        valid_n = i_ready ? 1'b0 : o_dout_valid;
        state_n = i_ready ? IDLE : OUTPUT;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_deserializer_fsm.sv
// tb_deserializer_fsm: directed table-driven checks of deserializer_fsm at LENGTH=8
module tb_deserializer_fsm;
  logic clk = 0, rst = 1, en = 1, din = 0, dv = 0, rdy = 0;
  logic o_ready, o_dout_valid;
  logic [7:0] ov_dout;
  int tests = 0, fails = 0;
  typedef struct {
    logic [7:0] seq;
    int gap_at;
    int gap_len;
    int wait_n;
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
  } vec_t;
  vec_t vecs[6];
  always #5 clk = ~clk;
  deserializer_fsm #(.LENGTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din), .i_din_valid(dv),
    .o_ready(o_ready), .ov_dout(ov_dout), .o_dout_valid(o_dout_valid), .i_ready(rdy)
  );
  task automatic tick(input logic r, e, d, v, rd);
    rst = r; en = e; din = d; dv = v; rdy = rd;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_ready();
    for (int k = 0; k < 4 && o_ready !== 1'b1; k++) tick(0, 1, 1, 1, 1);
    check("ready_timeout", o_ready, 1);
  endtask
  task automatic run_word(input logic [7:0] s, input int gap_at, gap_len, wait_n, input logic [7:0] exp);
    wait_ready();
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) begin
          tick(0, 1, 1, 0, 1);
          check("gap_ready", o_ready, 1);
          check("gap_valid", o_dout_valid, 0);
        end
      tick(0, 1, s[i], 1, wait_n == 0);
      if (i < 7) check("early_valid", o_dout_valid, 0);
    end
    check("done_valid", o_dout_valid, 1);
    check("done_dout", ov_dout, exp);
    check("done_ready", o_ready, 0);
    for (int w = 0; w < wait_n; w++) begin
      tick(0, 1, 1, w[0], 0);
      check("hold_valid", o_dout_valid, 1);
      check("hold_dout", ov_dout, exp);
      check("hold_ready", o_ready, 0);
    end
    tick(0, 1, 0, 0, 1);
    check("consume_valid", o_dout_valid, 0);
    check("consume_dout", ov_dout, exp);
  endtask
  function automatic logic [7:0] pick(input vec_t v);
`ifdef DESERIALIZER_MSB_FIRST_EN
    return v.exp_msb;
`else
    return v.exp_lsb;
`endif
  endfunction
  initial begin
    logic [7:0] s;
    vecs[0] = '{8'hA5, 8, 0, 0, 8'hA5, 8'hA5};
    vecs[1] = '{8'hA5, 4, 3, 0, 8'hA5, 8'hA5};
    vecs[2] = '{8'hA5, 8, 0, 5, 8'hA5, 8'hA5};
    vecs[3] = '{8'h3C, 2, 1, 0, 8'h3C, 8'h3C};
    vecs[4] = '{8'h03, 8, 0, 1, 8'h03, 8'hC0};
    vecs[5] = '{8'hB2, 7, 2, 2, 8'hB2, 8'h4D};
    tick(1, 1, 0, 0, 0);
    tick(1, 0, 1, 1, 1);
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_dout_valid, 0);
    check("rst_dout", ov_dout, 0);
    tick(0, 1, 1, 1, 0);
    check("idle_to_shift", o_ready, 1);
    for (int n = 0; n < 6; n++)
      run_word(vecs[n].seq, vecs[n].gap_at, vecs[n].gap_len, vecs[n].wait_n, pick(vecs[n]));
    wait_ready();
    s = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, s[i], 1, 1);
      check("partial_valid", o_dout_valid, 0);
    end
    tick(1, 1, 0, 1, 1);
    check("midrst_ready", o_ready, 0);
    check("midrst_valid", o_dout_valid, 0);
    check("midrst_dout", ov_dout, 0);
    run_word(8'hFF, 8, 0, 0, 8'hFF);
    wait_ready();
    for (int i = 0; i < 8; i++) begin
      if (i == 3)
        for (int f = 0; f < 4; f++) begin
          tick(0, 0, 1, 1, 1);
          check("frz_ready", o_ready, 1);
          check("frz_valid", o_dout_valid, 0);
          check("frz_dout", ov_dout, 8'hFF);
        end
      tick(0, 1, s[i], 1, 0);
    end
    check("frz_done_valid", o_dout_valid, 1);
    check("frz_done_dout", ov_dout, 8'h5A);
    for (int f = 0; f < 4; f++) begin
      tick(0, 0, 1, 1, 1);
      check("frzout_valid", o_dout_valid, 1);
      check("frzout_dout", ov_dout, 8'h5A);
      check("frzout_ready", o_ready, 0);
    end
    tick(0, 1, 0, 0, 1);
    check("frz_consume", o_dout_valid, 0);
    tick(0, 1, 0, 0, 1);
    check("frz_next_ready", o_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
